// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared divider state codes, handshake levels, bus widths and sign helper
package div_iter_pkg;
  localparam int RegBus = 32;
  localparam int DoubleRegBus = 64;
  localparam logic [1:0] DivFree = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn = 2'b10;
  localparam logic [1:0] DivEnd = 2'b11;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic [5:0] DivSteps = 6'd32;
  function automatic logic [RegBus-1:0] neg_if(input logic c, input logic [RegBus-1:0] v);
    return c ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step, (r,q,d) -> (r',q')
module div_step
  import div_iter_pkg::*;
(
  input  logic [RegBus-1:0] r_i,
  input  logic [RegBus-1:0] q_i,
  input  logic [RegBus-1:0] d_i,
  output logic [RegBus-1:0] r_o,
  output logic [RegBus-1:0] q_o
);
  logic [RegBus:0] t;
  always_comb begin
    t = {r_i, q_i[RegBus-1]} - {1'b0, d_i};
    r_o = t[RegBus] ? {r_i[RegBus-2:0], q_i[RegBus-1]} : t[RegBus-1:0];
    q_o = {q_i[RegBus-2:0], ~t[RegBus]};
  end
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative 32/32 restoring divider; start_i/annul_i/operands in, result_o {rem,quo} and ready_o out
module div_iter
  import div_iter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);
  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [RegBus-1:0] r_q, r_d, q_q, q_d, d_q, d_d, r_s, q_s;
  logic s1_q, s1_d, s2_q, s2_d, sd_q, sd_d;
  logic [DoubleRegBus-1:0] res_q, res_d;
  logic rdy_q, rdy_d;
  div_step u_step (.r_i(r_q), .q_i(q_q), .d_i(d_q), .r_o(r_s), .q_o(q_s));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    s1_d = s1_q;
    s2_d = s2_q;
    sd_d = sd_q;
    res_d = res_q;
    rdy_d = rdy_q;
    case (state_q)
      DivFree: begin
        res_d = '0;
        rdy_d = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) state_d = DivByZero;
          else begin
            state_d = DivOn;
            cnt_d = '0;
            r_d = '0;
            q_d = neg_if(signed_div_i & opdata1_i[RegBus-1], opdata1_i);
            d_d = neg_if(signed_div_i & opdata2_i[RegBus-1], opdata2_i);
            s1_d = opdata1_i[RegBus-1];
            s2_d = opdata2_i[RegBus-1];
            sd_d = signed_div_i;
          end
        end
      end
      DivByZero: begin
        state_d = annul_i ? DivFree : DivEnd;
        rdy_d = annul_i ? DivResultNotReady : DivResultReady;
        res_d = '0;
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          res_d = '0;
          rdy_d = DivResultNotReady;
        end else if (cnt_q != DivSteps) begin
          r_d = r_s;
          q_d = q_s;
          cnt_d = cnt_q + 6'd1;
        end else begin
          res_d = {neg_if(sd_q & s1_q, r_q), neg_if(sd_q & (s1_q ^ s2_q), q_q)};
          rdy_d = DivResultReady;
          state_d = DivEnd;
        end
      end
      default: begin
        if (start_i == DivStop) begin
          state_d = DivFree;
          res_d = '0;
          rdy_d = DivResultNotReady;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DivFree;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      sd_q <= 1'b0;
      res_q <= '0;
      rdy_q <= DivResultNotReady;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      sd_q <= sd_d;
      res_q <= res_d;
      rdy_q <= rdy_d;
    end
  end
  assign result_o = res_q;
  assign ready_o = rdy_q;
endmodule
